mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data requesters share one RAM port.
// Each transfer is a fixed LAT-cycle RAM access followed by a one-cycle hit pulse.
module mem_arbiter #(
   parameter int LAT = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          iREN,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] iload,
   output logic          ihit,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic [AW-1:0] daddr,
   input  logic [DW-1:0] dstore,
   output logic [DW-1:0] dload,
   output logic          dhit,
   output logic          ramREN,
   output logic          ramWEN,
   output logic [AW-1:0] ramaddr,
   output logic [DW-1:0] ramstore,
   input  logic [DW-1:0] ramload
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] IBUSY = 2'd1;
   localparam logic [1:0] DBUSY = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          gnt_data_q, gnt_data_d;   // current (and therefore last) grant went to data side
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] store_q, store_d;
   logic [DW-1:0] iload_q, iload_d;
   logic [DW-1:0] dload_q, dload_d;
   logic          dreq;

   assign dreq = dREN | dWEN;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_data_d = gnt_data_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      store_d    = store_q;
      iload_d    = iload_q;
      dload_d    = dload_q;
      unique case (state_q)
         IDLE: begin
            // Data wins a tie unless it also won the previous grant.
            if (dreq && !(iREN && gnt_data_q)) begin
               state_d    = DBUSY;
               cnt_d      = CNT_INIT;
               gnt_data_d = 1'b1;
               wr_d       = dWEN;
               addr_d     = daddr;
               store_d    = dstore;
            end else if (iREN) begin
               state_d    = IBUSY;
               cnt_d      = CNT_INIT;
               gnt_data_d = 1'b0;
               wr_d       = 1'b0;
               addr_d     = iaddr;
               store_d    = '0;
            end
         end
         IBUSY, DBUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               if (state_q == IBUSY) begin
                  iload_d = ramload;
               end else if (!wr_q) begin
                  dload_d = ramload;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         gnt_data_q <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         iload_q    <= '0;
         dload_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_data_q <= gnt_data_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         iload_q    <= iload_d;
         dload_q    <= dload_d;
      end
   end

   // RAM side is decoded from state so an asynchronous reset drops strobes at once.
   assign ramREN   = (state_q == IBUSY) || ((state_q == DBUSY) && !wr_q);
   assign ramWEN   = (state_q == DBUSY) && wr_q;
   assign ramaddr  = ((state_q == IBUSY) || (state_q == DBUSY)) ? addr_q : '0;
   assign ramstore = ramWEN ? store_q : '0;

   assign ihit  = (state_q == DONE) && !gnt_data_q;
   assign dhit  = (state_q == DONE) && gnt_data_q;
   assign iload = iload_q;
   assign dload = dload_q;

endmodule
